// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access stage.
package dmem_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_align.sv
// Store lane steering and load shift/extend for dmem_access.
// DMEM_MISALIGN_TRAP_EN: flag misaligned half/word and size 3 instead of masking the offset.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            offset,
  input  logic                  is_unsigned,
  input  logic [31:0]           st_data,
  input  logic [31:0]           ld_word,
  output logic [WORD_BYTES-1:0] st_be,
  output logic [31:0]           st_lanes,
  output logic [31:0]           ld_data,
  output logic                  misalign
);
  size_t       eff_size;
  logic [1:0]  eff_off;
  logic [31:0] shifted;

  always_comb begin
    eff_size = (size == 2'd3) ? WORD : size_t'(size);
    case (eff_size)
      BYTE:    eff_off = offset;
      HALF:    eff_off = {offset[1], 1'b0};
      default: eff_off = 2'd0;
    endcase
    shifted  = ld_word >> {eff_off, 3'b000};
    st_be    = '0;
    st_lanes = st_data;
    ld_data  = shifted;
    case (eff_size)
      BYTE: begin
        st_be    = 4'b0001 << eff_off;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = is_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        st_be    = 4'b0011 << eff_off;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = is_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: st_be = 4'b1111;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = (size == 2'd3) || ((size == HALF) && offset[0]) ||
                    ((size == WORD) && (offset != 2'd0));
`else
  assign misalign = 1'b0;
`endif
endmodule

// File: rtl/dmem_access.sv
// Load/store stage between the pipeline and port B of the byte-enabled data RAM.
// DMEM_MISALIGN_TRAP_EN (see dmem_align) turns misaligned accesses into error responses.
module dmem_access
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_en,
  output logic                  mem_rst,
  output logic [WORD_BYTES-1:0] mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic                  accept;
  logic [1:0]            al_size, al_off;
  logic                  al_uns;
  logic [WORD_BYTES-1:0] st_be;
  logic [31:0]           ld_data;
  logic                  misalign;
  logic                  unused_addr_hi;

  // One aligner serves both the accept cycle (live request) and READ (latched fields).
  assign al_size = (state_q == READ) ? size_q : req_size;
  assign al_off  = (state_q == READ) ? off_q  : req_addr[1:0];
  assign al_uns  = (state_q == READ) ? uns_q  : req_unsigned;

  dmem_align u_align (
    .size        (al_size),
    .offset      (al_off),
    .is_unsigned (al_uns),
    .st_data     (req_wdata),
    .ld_word     (mem_rdata),
    .st_be       (st_be),
    .st_lanes    (mem_wdata),
    .ld_data     (ld_data),
    .misalign    (misalign)
  );

  assign req_ready      = (state_q == IDLE) && !rstb;
  assign accept         = req_valid && req_ready;
  assign rsp_valid      = (state_q == RESP) && !rstb;
  assign rsp_rdata      = rstb ? '0 : rdata_q;
  assign rsp_error      = rstb ? 1'b0 : err_q;
  assign mem_rst        = rstb;
  assign mem_addr       = req_addr[AW+1:2];
  assign unused_addr_hi = ^req_addr[31:AW+2];

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_en  = 1'b0;
    mem_we  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d  = req_size;
          off_d   = req_addr[1:0];
          uns_d   = req_unsigned;
          rdata_d = '0;
          err_d   = misalign;
          if (misalign) begin
            state_d = RESP;
          end else begin
            mem_en = 1'b1;
            if (req_write) begin
              mem_we  = st_be;
              state_d = RESP;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        rdata_d = ld_data;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= IDLE;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_access.sv
// Directed scoreboard bench for dmem_access against a byte-enabled RAM model.
module tb_dmem_access;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_rst;
  logic [3:0]  mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] ram [0:1023];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access #(.DEPTH(1024)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_en(mem_en), .mem_rst(mem_rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: one-cycle read latency, output holds during writes.
  always @(posedge clk) begin
    if (mem_rst) mem_rdata <= '0;
    else if (mem_en) begin
      if (mem_we != 4'd0) begin
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit exp_en, input logic [3:0] exp_we,
                       input logic [31:0] exp_maddr, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
    chk("mem_we", {28'd0, mem_we}, {28'd0, exp_we});
    if (exp_en) chk("mem_addr", {22'd0, mem_addr}, exp_maddr);
    if (wr && exp_en) chk("mem_wdata", mem_wdata, exp_wd);
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Scramble fields so the stage must rely on what it latched.
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
  endtask

  task automatic collect();
    exp_t e;
    int cyc = 1;
    e = sb.pop_front();
    while (!rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_latency", cyc, e.lat);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
    @(negedge clk);
    chk("idle_after_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    exp_t e;
    int cyc;
    bit saw_valid;
    rstb = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_rst", {31'd0, mem_rst}, 32'd1);
    chk("rst_rsp", {rsp_rdata[30:0], rsp_error}, 32'd0);
    rstb = 1'b0;
    #1;
    chk("post_rst_ready", {30'd0, req_ready, mem_rst}, 32'd2);

    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 4, 32'hDEADBEEF, 32'h0, 0, 1); collect();
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 4'h0, 4, 0, 32'hDEADBEEF, 0, 2); collect();
    issue(1, 2'd0, 0, 32'h13, 32'h80, 1, 4'b1000, 4, 32'h80808080, 32'h0, 0, 1); collect();
    issue(0, 2'd0, 0, 32'h13, 32'h0, 1, 4'h0, 4, 0, 32'hFFFFFF80, 0, 2); collect();
    issue(0, 2'd0, 1, 32'h13, 32'h0, 1, 4'h0, 4, 0, 32'h00000080, 0, 2); collect();
    issue(1, 2'd2, 0, 32'h10, 32'h80011234, 1, 4'hF, 4, 32'h80011234, 32'h0, 0, 1); collect();
    issue(0, 2'd1, 0, 32'h12, 32'h0, 1, 4'h0, 4, 0, 32'hFFFF8001, 0, 2); collect();
    issue(0, 2'd1, 1, 32'h12, 32'h0, 1, 4'h0, 4, 0, 32'h00008001, 0, 2); collect();
    issue(1, 2'd2, 0, 32'h14, 32'h11112222, 1, 4'hF, 5, 32'h11112222, 32'h0, 0, 1); collect();
    issue(1, 2'd1, 0, 32'h16, 32'h0000ABCD, 1, 4'b1100, 5, 32'hABCDABCD, 32'h0, 0, 1); collect();
    issue(0, 2'd1, 1, 32'h16, 32'h0, 1, 4'h0, 5, 0, 32'h0000ABCD, 0, 2); collect();
    issue(0, 2'd2, 0, 32'h14, 32'h0, 1, 4'h0, 5, 0, 32'hABCD2222, 0, 2); collect();
    // Address above the RAM depth wraps onto word 4.
    issue(1, 2'd0, 0, 32'h1010, 32'hFFFFFF5A, 1, 4'b0001, 4, 32'h5A5A5A5A, 32'h0, 0, 1); collect();
    issue(0, 2'd0, 1, 32'h10, 32'h0, 1, 4'h0, 4, 0, 32'h0000005A, 0, 2); collect();
    issue(0, 2'd0, 0, 32'h11, 32'h0, 1, 4'h0, 4, 0, 32'h00000012, 0, 2); collect();

`ifdef DMEM_MISALIGN_TRAP_EN
    issue(0, 2'd2, 0, 32'h11, 32'h0, 0, 4'h0, 4, 0, 32'h0, 1, 1); collect();
    issue(0, 2'd3, 0, 32'h10, 32'h0, 0, 4'h0, 4, 0, 32'h0, 1, 1); collect();
    issue(0, 2'd1, 0, 32'h13, 32'h0, 0, 4'h0, 4, 0, 32'h0, 1, 1); collect();
    issue(1, 2'd2, 0, 32'h12, 32'h12345678, 0, 4'h0, 4, 0, 32'h0, 1, 1); collect();
`else
    issue(0, 2'd2, 0, 32'h11, 32'h0, 1, 4'h0, 4, 0, 32'h8001125A, 0, 2); collect();
    issue(0, 2'd3, 0, 32'h10, 32'h0, 1, 4'h0, 4, 0, 32'h8001125A, 0, 2); collect();
    issue(0, 2'd1, 0, 32'h13, 32'h0, 1, 4'h0, 4, 0, 32'hFFFF8001, 0, 2); collect();
`endif

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 4'h0, 4, 0, 32'h8001125A, 0, 2);
    e = sb.pop_front();
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_latency", cyc, e.lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata_hold", rsp_rdata, e.rdata);
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    // Consume while a new store waits: it must not be taken in the same cycle.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h0BADF00D;
    #1;
    chk("consume_no_accept", {30'd0, req_ready, mem_en}, 32'd0);
    @(negedge clk);
    chk("bp_idle_next", {30'd0, rsp_valid, req_ready}, 32'd1);
    chk("late_store_en", {28'd0, mem_we}, 32'hF);
    chk("late_store_addr", {22'd0, mem_addr}, 32'd16);
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'hFFFF_FFFF;
    collect();

    // Reset while in READ drops the load.
    issue(0, 2'd2, 0, 32'h40, 32'h0, 1, 4'h0, 16, 0, 32'h0BADF00D, 0, 2);
    void'(sb.pop_back());
    rstb = 1'b1;
    #1;
    chk("rst_read_en", {29'd0, mem_en, req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("rst_read_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("rst_read_no_rsp", {31'd0, saw_valid}, 32'd0);

    issue(0, 2'd2, 0, 32'h40, 32'h0, 1, 4'h0, 16, 0, 32'h0BADF00D, 0, 2); collect();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory access stage between the CPU execute/memory pipeline stage and port B of the dual-port byte-enabled block RAM. It accepts byte, halfword and word load/store requests over a valid/ready handshake. It converts each request into word-addressed RAM cycles with byte-lane enables, then returns load data shifted and sign- or zero-extended. The stage covers the RAM's one-cycle read latency and its NO_CHANGE write behaviour, so the pipeline sees a clean request/response protocol.

## Interface
- DEPTH, 1024: RAM depth in 32-bit words; `AW = $clog2(DEPTH)`.
- clk  in  1  clock; all logic on rising edge.
- rstb  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- rsp_error  out  1  request rejected; memory untouched.
- mem_en  out  1  RAM port enable.
- mem_rst  out  1  RAM output-latch reset.
- mem_we  out  4  byte write enables.
- mem_addr  out  AW  word address = req_addr[AW+1:2]; higher bits ignored, so addresses wrap.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM read data, valid the cycle after a read enable.

## Operation
- States: IDLE, READ, RESP. Reset value is IDLE.
- Outputs during and after reset: `req_ready` = 0 during reset, then 1. `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0, `mem_en` = 0, `mem_we` = 0. `mem_rst` = rstb.
- `req_ready` is 1 only in IDLE. A request is accepted on the cycle `req_valid && req_ready`.
- The RAM is driven combinationally during the accept cycle. `mem_en` = 1 unless the request has an error.
- Offset `o = req_addr[1:0]`.
- Store, byte: `mem_we = 4'b0001 << o`; `mem_wdata` = byte replicated ×4.
- Store, half: `mem_we = 4'b0011 << o`; `mem_wdata` = half replicated ×2.
- Store, word: `mem_we = 4'b1111`; `mem_wdata` as given.
- Loads drive `mem_we = 0`.
- State transitions:
  - IDLE, accepted load → READ.
  - IDLE, accepted store or error → RESP.
  - READ: captures `mem_rdata >> 8*o`, extends it per the latched size and unsigned flag into `rsp_rdata`, then → RESP.
  - RESP: holds `rsp_valid` = 1 and the response stable until `rsp_ready`, then → IDLE.
- No new request is accepted in the cycle where the response is consumed.
- Reset in any state returns to IDLE on the next edge. An in-flight response is dropped and no RAM access is issued in the reset cycle.

## Timing
- Load latency: accept at cycle N, RAM samples at edge N, `rsp_valid` from cycle N+2.
- Store/error latency: `rsp_valid` from cycle N+1.
- Maximum throughput: one request per 3 cycles for loads, 2 cycles for stores, with `rsp_ready` held high.
- Request fields are latched at accept; they may change afterwards.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with `o[0]` = 1, a word access with `o` ≠ 0, or size 3 gives `rsp_error` = 1.
  - In that case `mem_en` = 0 and `rsp_rdata` = 0.
- Not defined:
  - `o` is masked to the natural alignment: half uses `o & 2`, word uses 0.
  - Size 3 is treated as word.
  - `rsp_error` is tied to 0.

## Structure
- `dmem_pkg`: `size_t` enum (BYTE, HALF, WORD), `state_t` enum, `WORD_BYTES = 4`.
- Sub-module `dmem_align`: combinational store-lane steering and load shift/extend, shared by the write and READ paths.

## Test plan
- Word store 0xDEADBEEF to address 0x10, then word load from 0x10 → `mem_we = 4'hF`, `mem_addr = 4`; `rsp_rdata = 0xDEADBEEF` in cycle N+2.
- Byte store 0x80 to address 0x13, then signed byte load from 0x13 → `mem_we = 4'b1000`; `rsp_rdata = 0xFFFFFF80`. Unsigned byte load from 0x13 → `0x00000080`.
- Half load from address 0x12 of word 0x8001_1234: signed → `0xFFFF8001`; unsigned → `0x00008001`.
- Word load from address 0x11 with the macro defined → `rsp_error = 1`, `mem_en` never asserted. Without the macro → reads word 4.
- Hold `rsp_ready` = 0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready` = 0. Raise `rsp_ready` → IDLE next cycle.
- Assert rstb in READ → next cycle IDLE, `rsp_valid` = 0, no response emitted.
